fir_output_stage: RTL and testbench

FIR_OUTPUT_STAGE -- requirements
Module: fir_output_stage

---
 rtl/fir_output_stage.sv | 99 +++++++++
 tb/tb_fir_output_stage.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_output_stage.sv
// fir_output_stage: rounds and saturates FIR accumulator sums, then buffers them in a
// first-word-fall-through FIFO that drops and counts samples when it cannot accept them.
module fir_output_stage #(
    parameter int TAPS = 401,
    parameter int MULTBITS = 32,
    parameter int OUTBITS = 16,
    parameter int SHIFT = 15,
    parameter int DEPTH = 4,
    localparam int ACCUBITS = MULTBITS + $clog2(TAPS),
    localparam int LW = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [ACCUBITS-1:0] in_sum,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OUTBITS-1:0]  out_data,
    output logic                out_sat,
    output logic [LW-1:0]       level,
    output logic                ovf,
    output logic [15:0]         drop_count,
    input  logic                clr_ovf
);
    localparam int AW = $clog2(DEPTH);
    localparam logic signed [ACCUBITS:0] HALF = {{ACCUBITS{1'b0}}, 1'b1} << (SHIFT - 1);
    localparam logic signed [ACCUBITS:0] OMAX = {{(ACCUBITS - OUTBITS + 2){1'b0}}, {(OUTBITS - 1){1'b1}}};
    localparam logic signed [ACCUBITS:0] OMIN = ~OMAX;

    logic                       v1_q, v1_d, v2_q, v2_d, s2_q, s2_d, ovf_q, ovf_d;
    logic signed [ACCUBITS:0]   r1_q, r1_d, sum_x;
    logic [OUTBITS-1:0]         d2_q, d2_d;
    logic [AW-1:0]              wr_q, wr_d, rd_q, rd_d;
    logic [LW-1:0]              level_q, level_d;
    logic [15:0]                cnt_q, cnt_d;
    logic [OUTBITS:0]           mem [DEPTH];
    logic [OUTBITS:0]           head;
    logic                       pop, push, drop;

    // One extra bit of headroom keeps the half-LSB add from wrapping at the top of range.
    always_comb begin
        sum_x = {in_sum[ACCUBITS-1], in_sum};
        v1_d = in_valid;
        r1_d = in_valid ? (sum_x + HALF) >>> SHIFT : r1_q;
        v2_d = v1_q;
        d2_d = r1_q > OMAX ? OMAX[OUTBITS-1:0] : r1_q < OMIN ? OMIN[OUTBITS-1:0] : r1_q[OUTBITS-1:0];
        s2_d = (r1_q > OMAX) || (r1_q < OMIN);
    end

    // A full FIFO still accepts a write when the head leaves on the same edge.
    always_comb begin
        head = mem[rd_q];
        pop = out_valid && out_ready;
        push = v2_q && (level_q != LW'(DEPTH) || pop);
        drop = v2_q && !push;
        wr_d = wr_q + AW'(push);
        rd_d = rd_q + AW'(pop);
        level_d = level_q + LW'(push) - LW'(pop);
        ovf_d = !clr_ovf && (ovf_q || drop);
        cnt_d = clr_ovf ? '0 : (drop && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q <= 1'b0;
            r1_q <= '0;
            v2_q <= 1'b0;
            d2_q <= '0;
            s2_q <= 1'b0;
            wr_q <= '0;
            rd_q <= '0;
            level_q <= '0;
            ovf_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            v1_q <= v1_d;
            r1_q <= r1_d;
            v2_q <= v2_d;
            d2_q <= d2_d;
            s2_q <= s2_d;
            wr_q <= wr_d;
            rd_q <= rd_d;
            level_q <= level_d;
            ovf_q <= ovf_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_q] <= {s2_q, d2_q};
    end

    assign out_valid = level_q != '0;
    assign out_data = out_valid ? head[OUTBITS-1:0] : '0;
    assign out_sat = out_valid && head[OUTBITS];
    assign level = level_q;
    assign ovf = ovf_q;
    assign drop_count = cnt_q;
endmodule

// File: tb/tb_fir_output_stage.sv
// tb_fir_output_stage: directed checks of rounding, saturation, FIFO overflow,
// full-with-pop, streaming against a model, and mid-stream asynchronous reset.
module tb_fir_output_stage;
    logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0, clr_ovf = 1'b0;
    logic [40:0] in_sum = '0;
    logic        out_valid, out_sat, ovf;
    logic [15:0] out_data, drop_count;
    logic [2:0]  level;
    int          total = 0, bad = 0;

    fir_output_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sum(in_sum),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sat(out_sat), .level(level), .ovf(ovf), .drop_count(drop_count),
        .clr_ovf(clr_ovf)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic void model(input logic signed [40:0] v, output logic [15:0] d, output logic s);
        longint r;
        r = (longint'(v) + 64'sd16384) >>> 15;
        if (r > 32767) begin d = 16'h7FFF; s = 1'b1; end
        else if (r < -32768) begin d = 16'h8000; s = 1'b1; end
        else begin d = 16'(r); s = 1'b0; end
    endfunction

    task automatic test_reset;
        #3;
        total++;
        if (out_valid !== 1'b0 || level !== 3'd0 || out_data !== 16'd0 || out_sat !== 1'b0) begin
            bad++;
            $display("FAIL reset_async valid=%b level=%0d data=%h sat=%b want 0 0 0 0", out_valid, level, out_data, out_sat);
        end
        tick();
        tick();
        total++;
        if (ovf !== 1'b0 || drop_count !== 16'd0) begin
            bad++;
            $display("FAIL reset_ovf ovf=%b drop=%0d want 0 0", ovf, drop_count);
        end
        rst = 1'b0;
    endtask

    task automatic test_rounding;
        longint sums [3] = '{114688, -16384, -16385};
        int     exp_d [3] = '{4, 0, -1};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_sum = 41'(sums[i]);
            tick();
            in_valid = 1'b0;
            tick();
            total++;
            if (out_valid !== 1'b0) begin
                bad++;
                $display("FAIL round_early[%0d] valid=%b want 0", i, out_valid);
            end
            tick();
            total++;
            if (out_valid !== 1'b1 || out_data !== 16'(exp_d[i]) || out_sat !== 1'b0) begin
                bad++;
                $display("FAIL round[%0d] valid=%b data=%0d sat=%b want 1 %0d 0", i, out_valid, $signed(out_data), out_sat, exp_d[i]);
            end
            tick();
            total++;
            if (out_valid !== 1'b0) begin
                bad++;
                $display("FAIL round_pop[%0d] valid=%b want 0", i, out_valid);
            end
        end
    endtask

    task automatic test_saturation;
        longint sums [6] = '{64'sh0FF_FFFF_FFFF, -64'sh100_0000_0000, 1073709056, 1073725440, -1073758208, -1073758209};
        int     exp_d [6] = '{32767, -32768, 32767, 32767, -32768, -32768};
        logic   exp_s [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_sum = 41'(sums[i]);
            tick();
            in_valid = 1'b0;
            tick();
            tick();
            total++;
            if (out_valid !== 1'b1 || out_data !== 16'(exp_d[i]) || out_sat !== exp_s[i]) begin
                bad++;
                $display("FAIL sat[%0d] valid=%b data=%0d sat=%b want 1 %0d %b", i, out_valid, $signed(out_data), out_sat, exp_d[i], exp_s[i]);
            end
            tick();
        end
    endtask

    task automatic test_overflow;
        out_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            in_valid = 1'b1;
            in_sum = 41'(i * 32768);
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
        total++;
        if (level !== 3'd4 || drop_count !== 16'd2 || ovf !== 1'b1 || out_data !== 16'd1) begin
            bad++;
            $display("FAIL ovf_fill level=%0d drop=%0d ovf=%b data=%0d want 4 2 1 1", level, drop_count, ovf, out_data);
        end
        tick();
        tick();
        total++;
        if (out_valid !== 1'b1 || out_data !== 16'd1 || out_sat !== 1'b0) begin
            bad++;
            $display("FAIL ovf_hold valid=%b data=%0d sat=%b want 1 1 0", out_valid, out_data, out_sat);
        end
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            total++;
            if (out_valid !== 1'b1 || out_data !== 16'(i)) begin
                bad++;
                $display("FAIL ovf_drain[%0d] valid=%b data=%0d want 1 %0d", i, out_valid, out_data, i);
            end
            tick();
        end
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0 || level !== 3'd0 || ovf !== 1'b1 || drop_count !== 16'd2) begin
            bad++;
            $display("FAIL ovf_empty valid=%b level=%0d ovf=%b drop=%0d want 0 0 1 2", out_valid, level, ovf, drop_count);
        end
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        total++;
        if (ovf !== 1'b0 || drop_count !== 16'd0) begin
            bad++;
            $display("FAIL ovf_clear ovf=%b drop=%0d want 0 0", ovf, drop_count);
        end
    endtask

    task automatic test_full_pop;
        out_ready = 1'b0;
        for (int i = 11; i <= 14; i++) begin
            in_valid = 1'b1;
            in_sum = 41'(i * 32768);
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
        total++;
        if (level !== 3'd4) begin
            bad++;
            $display("FAIL full_fill level=%0d want 4", level);
        end
        in_valid = 1'b1;
        in_sum = 41'(15 * 32768);
        tick();
        in_valid = 1'b0;
        tick();
        out_ready = 1'b1;
        tick();
        total++;
        if (level !== 3'd4 || drop_count !== 16'd0 || ovf !== 1'b0 || out_data !== 16'd12) begin
            bad++;
            $display("FAIL full_pop level=%0d drop=%0d ovf=%b data=%0d want 4 0 0 12", level, drop_count, ovf, out_data);
        end
        for (int i = 12; i <= 15; i++) begin
            total++;
            if (out_valid !== 1'b1 || out_data !== 16'(i)) begin
                bad++;
                $display("FAIL full_drain[%0d] valid=%b data=%0d want 1 %0d", i, out_valid, out_data, i);
            end
            tick();
        end
        total++;
        if (out_valid !== 1'b0 || level !== 3'd0) begin
            bad++;
            $display("FAIL full_empty valid=%b level=%0d want 0 0", out_valid, level);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_stream;
        logic [16:0]        q [$];
        logic [16:0]        e;
        logic signed [40:0] v;
        logic [15:0]        d;
        logic               s;
        out_ready = 1'b1;
        for (int i = 0; i < 103; i++) begin
            if (i < 100) begin
                v = 41'({$urandom(), $urandom()});
                v = v >>> $urandom_range(0, 40);
                model(v, d, s);
                q.push_back({s, d});
                in_valid = 1'b1;
                in_sum = v;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            total++;
            if (out_valid !== (i >= 2 && i < 102) || level > 3'd1) begin
                bad++;
                $display("FAIL stream_rate[%0d] valid=%b level=%0d", i, out_valid, level);
            end
            if (out_valid === 1'b1 && q.size() > 0) begin
                e = q.pop_front();
                total++;
                if ({out_sat, out_data} !== e) begin
                    bad++;
                    $display("FAIL stream_data[%0d] sat=%b data=%h want %b %h", i, out_sat, out_data, e[16], e[15:0]);
                end
            end
        end
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL stream_count missing=%0d want 0", q.size());
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset_midstream;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_sum = 41'((20 + i) * 32768);
            tick();
        end
        in_valid = 1'b0;
        total++;
        if (level !== 3'd3) begin
            bad++;
            $display("FAIL mid_pre level=%0d want 3", level);
        end
        #1 rst = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0 || level !== 3'd0 || out_data !== 16'd0) begin
            bad++;
            $display("FAIL mid_async valid=%b level=%0d data=%0d want 0 0 0", out_valid, level, out_data);
        end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        total++;
        if (out_valid !== 1'b0 || level !== 3'd0 || ovf !== 1'b0) begin
            bad++;
            $display("FAIL mid_stale valid=%b level=%0d ovf=%b want 0 0 0", out_valid, level, ovf);
        end
        in_valid = 1'b1;
        in_sum = 41'(30 * 32768);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        total++;
        if (out_valid !== 1'b1 || out_data !== 16'd30 || level !== 3'd1) begin
            bad++;
            $display("FAIL mid_first valid=%b data=%0d level=%0d want 1 30 1", out_valid, out_data, level);
        end
        out_ready = 1'b1;
        tick();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL mid_after valid=%b want 0", out_valid);
        end
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_rounding();
        test_saturation();
        test_overflow();
        test_full_pop();
        test_stream();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
